systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder.sv | 123 ++++++++++++
 tb/tb_systolic_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for a DIM x DIM systolic MAC array: latches A and B on start,
// then streams them into the west/north edges with diagonal skew.
//
// state | meaning
// IDLE  | waiting for start; PE array held cleared
// CLEAR | one cycle with pe_start low to zero the accumulators
// RUN   | 3*DIM-2 skewed operand steps with pe_start high
// HOLD  | zero operands, pe_start high so results hold; done asserted
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]   a_mat_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]   b_mat_i,
  output logic [DIM*DATA_WIDTH-1:0]       a_row_o,
  output logic [DIM*DATA_WIDTH-1:0]       b_col_o,
  output logic                            pe_start_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int MW = DIM * DIM * DATA_WIDTH;
  localparam int VW = DIM * DATA_WIDTH;
  localparam int CW = $clog2(3 * DIM - 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(3 * DIM - 3);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   step, step_next;
  logic            capture;
  logic [MW-1:0]   a_mat, b_mat;
  logic [VW-1:0]   a_next, b_next;
  logic            pe_start_next, busy_next, done_next;
  int              ka, kb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  always_comb begin
    state_next    = state;
    step_next     = step;
    capture       = 1'b0;
    a_next        = '0;
    b_next        = '0;
    pe_start_next = 1'b0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    ka            = 0;
    kb            = 0;

    unique case (state)
      IDLE, HOLD: begin
        if (start_i) begin
          state_next = CLEAR;
          capture    = 1'b1;
        end
      end
      CLEAR: begin
        state_next = RUN;
        step_next  = '0;
      end
      RUN: begin
        if (step == LAST_STEP) begin
          state_next = HOLD;
          step_next  = '0;
        end else begin
          step_next = step + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they register in step with it.
    pe_start_next = (state_next == RUN) || (state_next == HOLD);
    busy_next     = (state_next == CLEAR) || (state_next == RUN);
    done_next     = (state_next == HOLD);

    if (state_next == RUN) begin
      for (int i = 0; i < DIM; i++) begin
        ka = int'(step_next) - i;
        if (ka >= 0 && ka < DIM)
          a_next[i*DATA_WIDTH +: DATA_WIDTH] = a_mat[(i*DIM+ka)*DATA_WIDTH +: DATA_WIDTH];
        kb = int'(step_next) - i;
        if (kb >= 0 && kb < DIM)
          b_next[i*DATA_WIDTH +: DATA_WIDTH] = b_mat[(kb*DIM+i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_mat      <= '0;
      b_mat      <= '0;
      a_row_o    <= '0;
      b_col_o    <= '0;
      pe_start_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      if (capture) begin
        a_mat <= a_mat_i;
        b_mat <= b_mat_i;
      end
      a_row_o    <= a_next;
      b_col_o    <= b_next;
      pe_start_o <= pe_start_next;
      busy_o     <= busy_next;
      done_o     <= done_next;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: DIM=4 and DIM=2 instances feeding a
// behavioural PE array, checked against hand-computed operands and products.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         st4, ps4, bz4, dn4;
  logic [127:0] a4, b4;
  logic [31:0]  ar4, bc4;
  logic         st2, ps2, bz2, dn2;
  logic [31:0]  a2m, b2m;
  logic [15:0]  ar2, bc2;

  int n_cmp = 0;
  int n_err = 0;

  systolic_feeder #(.DATA_WIDTH(8), .DIM(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(st4), .a_mat_i(a4), .b_mat_i(b4),
    .a_row_o(ar4), .b_col_o(bc4), .pe_start_o(ps4), .busy_o(bz4), .done_o(dn4));

  systolic_feeder #(.DATA_WIDTH(8), .DIM(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(st2), .a_mat_i(a2m), .b_mat_i(b2m),
    .a_row_o(ar2), .b_col_o(bc2), .pe_start_o(ps2), .busy_o(bz2), .done_o(dn2));

  // Behavioural PE arrays: clear when pe_start low, else acc += a*b and pass operands.
  logic signed [7:0]  ah4[4][4], bv4[4][4];
  logic signed [31:0] acc4[4][4];
  logic signed [7:0]  ah2[2][2], bv2[2][2];
  logic signed [31:0] acc2[2][2];

  function automatic logic signed [7:0] a_in4(int i, int j);
    if (j == 0) return ar4[i*8 +: 8];
    return ah4[i][j-1];
  endfunction
  function automatic logic signed [7:0] b_in4(int i, int j);
    if (i == 0) return bc4[j*8 +: 8];
    return bv4[i-1][j];
  endfunction
  function automatic logic signed [7:0] a_in2(int i, int j);
    if (j == 0) return ar2[i*8 +: 8];
    return ah2[i][j-1];
  endfunction
  function automatic logic signed [7:0] b_in2(int i, int j);
    if (i == 0) return bc2[j*8 +: 8];
    return bv2[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (rst || !ps4) begin
          acc4[i][j] <= '0; ah4[i][j] <= '0; bv4[i][j] <= '0;
        end else begin
          acc4[i][j] <= acc4[i][j] + a_in4(i, j) * b_in4(i, j);
          ah4[i][j]  <= a_in4(i, j);
          bv4[i][j]  <= b_in4(i, j);
        end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (rst || !ps2) begin
          acc2[i][j] <= '0; ah2[i][j] <= '0; bv2[i][j] <= '0;
        end else begin
          acc2[i][j] <= acc2[i][j] + a_in2(i, j) * b_in2(i, j);
          ah2[i][j]  <= a_in2(i, j);
          bv2[i][j]  <= b_in2(i, j);
        end
  end

  // Expected west/north edge vectors for step t of a 4x4 matrix.
  function automatic logic [31:0] exp_a(logic [127:0] m, int t);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) r[i*8 +: 8] = m[(i*4 + t - i)*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] exp_b(logic [127:0] m, int t);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) r[j*8 +: 8] = m[((t - j)*4 + j)*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs4(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic ep, input logic ebz, input logic ed);
    chk({tag, " a_row"}, ar4, ea);
    chk({tag, " b_col"}, bc4, eb);
    chk({tag, " pe_start"}, ps4, ep);
    chk({tag, " busy"}, bz4, ebz);
    chk({tag, " done"}, dn4, ed);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start4;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
  endtask

  logic [127:0] ident, seqm, skew;

  initial begin
    rst = 1'b1; st4 = 1'b0; st2 = 1'b0;
    a4 = '0; b4 = '0; a2m = '0; b2m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ident[(r*4+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
        seqm[(r*4+c)*8 +: 8]  = 8'(r*4 + c);
        skew[(r*4+c)*8 +: 8]  = 8'(16*r + c + 1);
      end
    tick(); tick();
    chk_outs4("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset dim2 busy", bz2, 1'b0);
    rst = 1'b0;
    tick();
    chk_outs4("idle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Identity x sequence; inputs scrambled after capture.
    a4 = ident; b4 = seqm;
    start4();
    a4 = '1; b4 = '1;
    chk_outs4("t1 c1", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= 11; c++) begin
      tick();
      chk($sformatf("t1 a_row c%0d", c), ar4, exp_a(ident, c - 2));
      chk($sformatf("t1 b_col c%0d", c), bc4, exp_b(seqm, c - 2));
      chk($sformatf("t1 pe_start c%0d", c), ps4, 1'b1);
    end
    chk("t1 c2 b_col hand", exp_b(seqm, 0), 32'h0);
    tick();
    chk_outs4("t1 c12", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t1 res23", acc4[2][3], 64'd11);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("t1 res%0d%0d", i, j), acc4[i][j], 64'(i*4 + j));
    tick();
    chk("t1 c13 done held", dn4, 1'b1);
    chk("t1 c13 res23 held", acc4[2][3], 64'd11);

    // Signed pass-through.
    a4 = {16{8'h80}}; b4 = {16{8'hFF}};
    start4();
    tick();
    chk("sg c2 a_row", ar4, 32'h00000080);
    chk("sg c2 b_col", bc4, 32'h000000FF);
    tick(); tick(); tick();
    chk("sg c5 a_row", ar4, 32'h80808080);
    chk("sg c5 b_col", bc4, 32'hFFFFFFFF);
    tick(); tick(); tick();
    chk("sg c8 a_row", ar4, 32'h80000000);
    chk("sg c8 b_col", bc4, 32'hFF000000);
    tick(); tick(); tick(); tick();
    chk("sg c12 done", dn4, 1'b1);
    chk("sg res00", acc4[0][0], 64'd512);
    chk("sg res33", acc4[3][3], 64'd512);
    chk("sg res12", acc4[1][2], 64'd512);

    // Reset in the middle of RUN.
    a4 = ident; b4 = seqm;
    start4();
    for (int c = 2; c <= 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs4("rst c7", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs4("rst idle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    start4();
    for (int c = 2; c <= 11; c++) tick();
    chk("rst2 c11 done", dn4, 1'b0);
    chk("rst2 c11 busy", bz4, 1'b1);
    tick();
    chk("rst2 c12 done", dn4, 1'b1);
    chk("rst2 res23", acc4[2][3], 64'd11);
    chk("rst2 res31", acc4[3][1], 64'd13);

    // start ignored during RUN, then re-armed from HOLD.
    a4 = ident; b4 = seqm;
    start4();
    for (int c = 2; c <= 5; c++) tick();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    chk("ign c6 pe_start", ps4, 1'b1);
    chk("ign c6 busy", bz4, 1'b1);
    for (int c = 7; c <= 11; c++) tick();
    chk("ign c11 done", dn4, 1'b0);
    tick();
    chk("ign c12 done", dn4, 1'b1);
    tick();
    chk("ign c13 done", dn4, 1'b1);
    tick();
    a4 = skew; b4 = {16{8'h05}};
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    a4 = '0; b4 = '0;
    chk_outs4("hold c15", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sk t0 a_row", ar4, 32'h00000001);
    chk("sk t0 b_col", bc4, 32'h00000005);
    tick();
    chk("sk t1 a_row", ar4, 32'h00001102);
    chk("sk t1 b_col", bc4, 32'h00000505);
    for (int rc = 4; rc <= 11; rc++) begin
      tick();
      chk($sformatf("sk a_row rc%0d", rc), ar4, exp_a(skew, rc - 2));
      if (rc == 5) chk("sk t3 a_row hand", ar4, 32'h31221304);
      if (rc == 8) begin
        chk("sk t6 a_row hand", ar4, 32'h34000000);
        st4 = 1'b1;
      end
      if (rc == 11) chk("sk t9 a_row hand", ar4, 32'h0);
    end
    tick();
    chk_outs4("loop hold", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    tick();
    st4 = 1'b0;
    chk_outs4("loop clear", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= 12; c++) tick();
    chk("loop done", dn4, 1'b1);

    // DIM=2 instance.
    a2m = {8'd4, 8'd3, 8'd2, 8'd1};
    b2m = {8'd8, 8'd7, 8'd6, 8'd5};
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk("d2 c1 busy", bz2, 1'b1);
    chk("d2 c1 pe_start", ps2, 1'b0);
    tick();
    chk("d2 c2 a_row", ar2, 16'h0001);
    chk("d2 c2 b_col", bc2, 16'h0005);
    tick();
    chk("d2 c3 a_row", ar2, 16'h0302);
    chk("d2 c3 b_col", bc2, 16'h0607);
    tick();
    chk("d2 c4 a_row", ar2, 16'h0400);
    chk("d2 c4 b_col", bc2, 16'h0800);
    tick();
    chk("d2 c5 busy", bz2, 1'b1);
    chk("d2 c5 done", dn2, 1'b0);
    tick();
    chk("d2 c6 done", dn2, 1'b1);
    chk("d2 c6 busy", bz2, 1'b0);
    chk("d2 res00", acc2[0][0], 64'd19);
    chk("d2 res01", acc2[0][1], 64'd22);
    chk("d2 res10", acc2[1][0], 64'd43);
    chk("d2 res11", acc2[1][1], 64'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
